skid_mux_nbit: RTL and testbench

//  Parametrised INPUTS-way, N-bit registered operand selector with valid/ready handshake.
//  A 2-entry skid buffer gives 1-cycle latency and full throughput under back-pressure.
//  Out-of-range selects produce zero and are flagged and counted for debug.

---
 rtl/skid_mux_nbit.sv | 122 ++++++++++++
 tb/tb_skid_mux_nbit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/skid_mux_nbit.sv
// skid_mux_nbit: INPUTS-way N-bit registered operand selector with a 2-entry
// skid buffer. A word accepted at one edge appears on out_data after that edge.
// The block keeps full throughput while out_ready is high. Illegal selects
// deliver zero, raise out_sel_err and bump a saturating debug counter.
module skid_mux_nbit #(
  parameter int N      = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INPUTS*N-1:0]   in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N-1:0]          out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  err_clr,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   main_data, skid_data, word;
  logic           main_err, skid_err, word_err;
  logic           rdy, accept;

  // Channel select: zero word and error flag when no channel matches sel
  always_comb begin
    word     = '0;
    word_err = 1'b1;
    for (int k = 0; k < INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        word     = in_bus[k*N +: N];
        word_err = 1'b0;
      end
    end
  end

  assign accept = in_valid & rdy;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !out_ready)      state_nxt = FULL;
        else if (!accept && out_ready) state_nxt = EMPTY;
      end
      FULL:    if (out_ready) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output decode; in_ready comes from a flop so it never depends on out_ready
  always_comb begin
    out_valid   = (state != EMPTY);
    in_ready    = rdy;
    out_data    = main_data;
    out_sel_err = main_err;
  end

  // Ready flop: low during reset, otherwise high unless heading into FULL
  always_ff @(posedge clk) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= (state_nxt != FULL);
  end

  // Main/skid datapath; main changes only on an output transfer or when empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_data <= word;
          main_err  <= word_err;
        end
        ONE: begin
          if (accept && out_ready) begin
            main_data <= word;
            main_err  <= word_err;
          end else if (accept) begin
            skid_data <= word;
            skid_err  <= word_err;
          end
        end
        FULL: if (out_ready) begin
          main_data <= skid_data;
          main_err  <= skid_err;
          skid_data <= '0;
          skid_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating illegal-select counter; a clear plus an illegal accept leaves 1
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (err_clr)
      err_count <= (accept && word_err) ? 8'd1 : 8'd0;
    else if (accept && word_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_skid_mux_nbit.sv
// Directed bench for skid_mux_nbit: a 4-input instance covers reset, streaming,
// back-pressure and reset-while-full; a 3-input instance covers illegal selects.
module tb_skid_mux_nbit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // 4-input instance
  logic [127:0] bus4;
  logic [1:0]   sel4;
  logic         iv4, ir4, os4, ov4, or4, clr4;
  logic [31:0]  od4;
  logic [7:0]   ec4;

  // 3-input instance
  logic [95:0]  bus3;
  logic [1:0]   sel3;
  logic         iv3, ir3, os3, ov3, or3, clr3;
  logic [31:0]  od3;
  logic [7:0]   ec3;

  skid_mux_nbit #(.N(32), .INPUTS(4), .SEL_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus4), .sel(sel4), .in_valid(iv4),
    .in_ready(ir4), .out_data(od4), .out_sel_err(os4), .out_valid(ov4),
    .out_ready(or4), .err_clr(clr4), .err_count(ec4));

  skid_mux_nbit #(.N(32), .INPUTS(3), .SEL_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_bus(bus3), .sel(sel3), .in_valid(iv3),
    .in_ready(ir3), .out_data(od3), .out_sel_err(os3), .out_valid(ov3),
    .out_ready(or3), .err_clr(clr3), .err_count(ec3));

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv4 = 0; or4 = 0; clr4 = 0; sel4 = 0; bus4 = '0;
    iv3 = 0; or3 = 0; clr3 = 0; sel3 = 0; bus3 = '0;
    cyc(); cyc();
    vectors++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", ov4); end
    vectors++; if (od4 !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", od4); end
    vectors++; if (ec4 !== 8'h0)  begin errors++; $display("FAIL reset_err_count got %0d want 0", ec4); end
    vectors++; if (ir4 !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", ir4); end
    vectors++; if (ir3 !== 1'b0)  begin errors++; $display("FAIL reset_in_ready3 got %b want 0", ir3); end
    rst_n = 1'b1;
    cyc();
    vectors++; if (ir4 !== 1'b1)  begin errors++; $display("FAIL release_in_ready got %b want 1", ir4); end
    vectors++; if (ov4 !== 1'b0)  begin errors++; $display("FAIL release_out_valid got %b want 0", ov4); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    bus4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    or4  = 1'b1;
    iv4  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      cyc();
      vectors++;
      if (ov4 !== 1'b1 || od4 !== exp_d[i] || os4 !== 1'b0 || ir4 !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h e=%b r=%b want v=1 d=%h e=0 r=1",
                 i, ov4, od4, os4, ir4, exp_d[i]);
      end
    end
    iv4 = 1'b0;
    cyc();
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL stream_drain got v=%b want 0", ov4); end
  endtask

  task automatic test_back_pressure();
    bus4 = '0;
    bus4[31:0]  = 32'h11;
    bus4[63:32] = 32'h22;
    or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
    cyc();
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 32'h11 || ir4 !== 1'b1) begin
      errors++; $display("FAIL bp_first got v=%b d=%h r=%b want v=1 d=11 r=1", ov4, od4, ir4);
    end
    sel4 = 2'd1;
    cyc();
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 32'h11 || ir4 !== 1'b0) begin
      errors++; $display("FAIL bp_full got v=%b d=%h r=%b want v=1 d=11 r=0", ov4, od4, ir4);
    end
    // Stalled: X on unused inputs must not disturb the held word
    iv4 = 1'b0; sel4 = 'x; bus4 = 'x;
    cyc();
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 32'h11 || os4 !== 1'b0 || ir4 !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h e=%b r=%b want v=1 d=11 e=0 r=0", ov4, od4, os4, ir4);
    end
    or4 = 1'b1;
    cyc();
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 32'h22 || ir4 !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b d=%h r=%b want v=1 d=22 r=1", ov4, od4, ir4);
    end
    cyc();
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b want 0", ov4); end
    sel4 = 2'd0; bus4 = '0;
  endtask

  task automatic test_illegal_sel();
    bus3 = {3{32'hFFFF_FFFF}};
    or3 = 1'b1; iv3 = 1'b1; sel3 = 2'd3;
    cyc();
    vectors++;
    if (ov3 !== 1'b1 || od3 !== 32'h0 || os3 !== 1'b1 || ec3 !== 8'd1) begin
      errors++; $display("FAIL illegal got v=%b d=%h e=%b cnt=%0d want v=1 d=0 e=1 cnt=1", ov3, od3, os3, ec3);
    end
    sel3 = 2'd2;
    cyc();
    vectors++;
    if (od3 !== 32'hFFFF_FFFF || os3 !== 1'b0 || ec3 !== 8'd1) begin
      errors++; $display("FAIL legal_after got d=%h e=%b cnt=%0d want d=ffffffff e=0 cnt=1", od3, os3, ec3);
    end
  endtask

  task automatic test_saturation();
    sel3 = 2'd3; iv3 = 1'b1; or3 = 1'b1;
    for (int i = 0; i < 260; i++) cyc();
    vectors++; if (ec3 !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", ec3); end
    clr3 = 1'b1;
    cyc();
    vectors++; if (ec3 !== 8'd1) begin errors++; $display("FAIL clr_with_err got %0d want 1", ec3); end
    iv3 = 1'b0;
    cyc();
    vectors++; if (ec3 !== 8'd0) begin errors++; $display("FAIL clr_alone got %0d want 0", ec3); end
    clr3 = 1'b0;
  endtask

  task automatic test_reset_full();
    bus4 = '0;
    bus4[31:0]  = 32'h11;
    bus4[63:32] = 32'h22;
    bus4[95:64] = 32'h55;
    or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
    cyc();
    sel4 = 2'd1;
    cyc();
    vectors++; if (ir4 !== 1'b0) begin errors++; $display("FAIL rf_full got r=%b want 0", ir4); end
    iv4 = 1'b0; rst_n = 1'b0;
    cyc();
    vectors++;
    if (ov4 !== 1'b0 || ir4 !== 1'b0 || od4 !== 32'h0) begin
      errors++; $display("FAIL rf_reset got v=%b r=%b d=%h want v=0 r=0 d=0", ov4, ir4, od4);
    end
    rst_n = 1'b1;
    cyc();
    vectors++; if (ir4 !== 1'b1) begin errors++; $display("FAIL rf_release got r=%b want 1", ir4); end
    or4 = 1'b1; iv4 = 1'b1; sel4 = 2'd2;
    cyc();
    vectors++;
    if (ov4 !== 1'b1 || od4 !== 32'h55) begin
      errors++; $display("FAIL rf_new got v=%b d=%h want v=1 d=55", ov4, od4);
    end
    iv4 = 1'b0;
    cyc();
    vectors++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rf_alone got v=%b want 0", ov4); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_illegal_sel();
    test_saturation();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
